el2_dccm_bank_sink: RTL and testbench

//  Memory-side responder for the exported DCCM SRAM bus. It consumes per-bank clken/wren/addr/data/ecc and returns

---
 rtl/el2_dccm_bank_sink_pkg.sv | 35 +++
 rtl/el2_dccm_bank_sink_ram.sv | 51 +++++
 rtl/el2_dccm_bank_sink.sv | 156 +++++++++++++++
 tb/tb_el2_dccm_bank_sink.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/el2_dccm_bank_sink_pkg.sv
// el2_dccm_bank_sink_pkg
//   Shared types for the DCCM bank sink: injector FSM state, the captured
//   injector configuration record, default geometry and a saturating
//   counter helper.
`timescale 1ns/1ps
package el2_dccm_bank_sink_pkg;

    // Default geometry. The captured injector record is sized from these,
    // so a top-level instance is expected to use the same values.
    localparam int PKG_NUM_BANKS   = 4;
    localparam int PKG_INDEX_DEPTH = 1024;
    localparam int PKG_DATA_WIDTH  = 32;
    localparam int PKG_ECC_WIDTH   = 7;
    localparam int PKG_BANK_BITS   = (PKG_NUM_BANKS > 1) ? $clog2(PKG_NUM_BANKS) : 1;
    localparam int PKG_ADDR_BITS   = $clog2(PKG_INDEX_DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } el2_dccm_inj_state_t;

    typedef struct packed {
        logic [PKG_BANK_BITS-1:0]  bank;
        logic [PKG_ADDR_BITS-1:0]  addr;
        logic [PKG_DATA_WIDTH-1:0] dmask;
        logic [PKG_ECC_WIDTH-1:0]  emask;
        logic                      sticky;
    } el2_dccm_inj_cfg_t;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/el2_dccm_bank_sink_ram.sv
// el2_dccm_bank_ram
//   One single-port DCCM bank. Stores {ecc,data} rows, 1-cycle registered
//   read, read register holds whenever the bank is not read.
//   Ports:
//     clk, rst_l   clock, synchronous active-low reset (read register only)
//     clken_i      access enable
//     wren_i       write when enabled, read otherwise
//     addr_i       row address
//     wdata_i      {ecc,data} write row
//     rdata_o      registered read row
//   Rows at or beyond DEPTH do not exist: writes to them are dropped and
//   reads of them return zero.
`timescale 1ns/1ps
module el2_dccm_bank_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             clken_i,
    input  logic             wren_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic             in_range;

    assign in_range = ({1'b0, addr_i} < (AW+1)'(DEPTH));

    // Array contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (clken_i && wren_i && in_range) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rdata_q <= '0;
        end else if (clken_i && !wren_i) begin
            rdata_q <= in_range ? mem[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/el2_dccm_bank_sink.sv
// el2_dccm_bank_sink
//   Memory-side responder for the exported DCCM SRAM bus: NB independent
//   single-port banks with 1-cycle read latency, plus a one-shot / sticky
//   read-error injector that XORs masks into returned reads (never into
//   the stored array).
//   Ports:
//     clk, rst_l              clock, synchronous active-low reset
//     dccm_clken              per-bank access enable
//     dccm_wren_bank          per-bank write (only with clken)
//     dccm_addr_bank          per-bank row address
//     dccm_wr_data_bank/ecc   per-bank write data / ecc
//     dccm_bank_dout/ecc      per-bank read data / ecc, 1 cycle after read
//     inj_en / inj_clr        arm / disarm pulses (clr wins)
//     inj_sticky              corrupt every matching read while armed
//     inj_bank/addr           injector target
//     inj_data_mask/ecc_mask  XOR masks for the corrupted read
//     inj_armed               injector in ARMED
//     inj_count               corrupted-read count, saturating at 255
`timescale 1ns/1ps
module el2_dccm_bank_sink
    import el2_dccm_bank_sink_pkg::*;
#(
    parameter int DCCM_NUM_BANKS   = PKG_NUM_BANKS,
    parameter int DCCM_INDEX_DEPTH = PKG_INDEX_DEPTH,
    parameter int DCCM_DATA_WIDTH  = PKG_DATA_WIDTH,
    parameter int DCCM_ECC_WIDTH   = PKG_ECC_WIDTH,
    localparam int NB = DCCM_NUM_BANKS,
    localparam int AW = $clog2(DCCM_INDEX_DEPTH),
    localparam int DW = DCCM_DATA_WIDTH,
    localparam int EW = DCCM_ECC_WIDTH,
    localparam int BW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                   clk,
    input  logic                   rst_l,

    input  logic [NB-1:0]          dccm_clken,
    input  logic [NB-1:0]          dccm_wren_bank,
    input  logic [NB-1:0][AW-1:0]  dccm_addr_bank,
    input  logic [NB-1:0][DW-1:0]  dccm_wr_data_bank,
    input  logic [NB-1:0][EW-1:0]  dccm_wr_ecc_bank,
    output logic [NB-1:0][DW-1:0]  dccm_bank_dout,
    output logic [NB-1:0][EW-1:0]  dccm_bank_ecc,

    input  logic                   inj_en,
    input  logic                   inj_sticky,
    input  logic                   inj_clr,
    input  logic [BW-1:0]          inj_bank,
    input  logic [AW-1:0]          inj_addr,
    input  logic [DW-1:0]          inj_data_mask,
    input  logic [EW-1:0]          inj_ecc_mask,
    output logic                   inj_armed,
    output logic [7:0]             inj_count
);

    el2_dccm_inj_state_t state_q, state_d;
    el2_dccm_inj_cfg_t   cfg_q, cfg_d;
    logic [7:0]          count_q, count_d;

    logic tgt_rd;   // read of the captured bank/row this cycle
    logic tgt_wr;   // write of the captured bank/row this cycle
    logic hit;      // tgt_rd that actually gets corrupted

    // Target match always uses the currently captured fields, so an inj_en
    // in the same cycle as a hit cannot retarget that hit.
    always_comb begin
        tgt_rd = dccm_clken[cfg_q.bank] && !dccm_wren_bank[cfg_q.bank] &&
                 (dccm_addr_bank[cfg_q.bank] == cfg_q.addr);
        tgt_wr = dccm_clken[cfg_q.bank] &&  dccm_wren_bank[cfg_q.bank] &&
                 (dccm_addr_bank[cfg_q.bank] == cfg_q.addr);
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        count_d = count_q;
        hit     = 1'b0;

        if (inj_clr) begin
            // Disarm wins over arm and suppresses any same-cycle hit.
            state_d = IDLE;
        end else begin
            case (state_q)
                ARMED: begin
                    hit = tgt_rd;
                    // One-shot retires on its hit; a write to the target
                    // overwrites the row the error was meant for.
                    if (!cfg_q.sticky && (tgt_rd || tgt_wr)) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase

            if (inj_en) begin
                state_d      = ARMED;
                cfg_d.bank   = inj_bank;
                cfg_d.addr   = inj_addr;
                cfg_d.dmask  = inj_data_mask;
                cfg_d.emask  = inj_ecc_mask;
                cfg_d.sticky = inj_sticky;
            end
        end

        if (hit) begin
            count_d = sat_inc8(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            count_q <= count_d;
        end
    end

    assign inj_armed = (state_q == ARMED);
    assign inj_count = count_q;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [EW+DW-1:0] rdata;
        logic [EW+DW-1:0] xmask_q;

        el2_dccm_bank_ram #(
            .DEPTH (DCCM_INDEX_DEPTH),
            .AW    (AW),
            .WIDTH (EW+DW)
        ) u_ram (
            .clk     (clk),
            .rst_l   (rst_l),
            .clken_i (dccm_clken[b]),
            .wren_i  (dccm_wren_bank[b]),
            .addr_i  (dccm_addr_bank[b]),
            .wdata_i ({dccm_wr_ecc_bank[b], dccm_wr_data_bank[b]}),
            .rdata_o (rdata)
        );

        // Mask is latched alongside the read and held with it, so a held
        // corrupted read stays corrupted and a later re-arm cannot alter it.
        always_ff @(posedge clk) begin
            if (!rst_l) begin
                xmask_q <= '0;
            end else if (dccm_clken[b] && !dccm_wren_bank[b]) begin
                xmask_q <= (hit && (cfg_q.bank == BW'(b))) ?
                           {cfg_q.emask, cfg_q.dmask} : '0;
            end
        end

        assign {dccm_bank_ecc[b], dccm_bank_dout[b]} = rdata ^ xmask_q;
    end

endmodule

// File: tb/tb_el2_dccm_bank_sink.sv
`timescale 1ns/1ps
module tb_el2_dccm_bank_sink;
    localparam int NB = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_l;
    logic [NB-1:0]         clken, wren;
    logic [NB-1:0][AW-1:0] addr;
    logic [NB-1:0][DW-1:0] wd;
    logic [NB-1:0][EW-1:0] we;
    logic [NB-1:0][DW-1:0] dout;
    logic [NB-1:0][EW-1:0] ecc;
    logic                  inj_en, inj_sticky, inj_clr;
    logic [1:0]            inj_bank;
    logic [AW-1:0]         inj_addr;
    logic [DW-1:0]         inj_dmask;
    logic [EW-1:0]         inj_emask;
    logic                  inj_armed;
    logic [7:0]            inj_count;

    el2_dccm_bank_sink dut (
        .clk               (clk),
        .rst_l             (rst_l),
        .dccm_clken        (clken),
        .dccm_wren_bank    (wren),
        .dccm_addr_bank    (addr),
        .dccm_wr_data_bank (wd),
        .dccm_wr_ecc_bank  (we),
        .dccm_bank_dout    (dout),
        .dccm_bank_ecc     (ecc),
        .inj_en            (inj_en),
        .inj_sticky        (inj_sticky),
        .inj_clr           (inj_clr),
        .inj_bank          (inj_bank),
        .inj_addr          (inj_addr),
        .inj_data_mask     (inj_dmask),
        .inj_ecc_mask      (inj_emask),
        .inj_armed         (inj_armed),
        .inj_count         (inj_count)
    );

    // Reference model: memory as a sparse map, last returned read per bank,
    // injector as a handful of plain variables.
    logic [EW+DW-1:0] m_mem [int];
    logic [EW+DW-1:0] m_out [NB];
    bit               m_armed, m_sticky;
    int               m_bank, m_addr, m_count;
    logic [EW+DW-1:0] m_mask;

    int n_checks = 0;
    int n_pass   = 0;

    int rows [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 16};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        clken = '0; wren = '0; addr = '0; wd = '0; we = '0;
        inj_en = 0; inj_clr = 0; inj_sticky = 0; inj_bank = '0;
        inj_addr = '0; inj_dmask = '0; inj_emask = '0;
    endtask

    task automatic model_update();
        bit hit, kill;
        logic [EW+DW-1:0] val;
        int key;
        hit = 0; kill = 0;
        if (!rst_l) begin
            for (int b = 0; b < NB; b++) m_out[b] = '0;
            m_armed = 0; m_count = 0;
            return;
        end
        for (int b = 0; b < NB; b++) begin
            if (clken[b]) begin
                key = b * DEPTH + int'(addr[b]);
                if (wren[b]) begin
                    m_mem[key] = {we[b], wd[b]};
                    if (m_armed && !inj_clr && !m_sticky && b == m_bank && int'(addr[b]) == m_addr)
                        kill = 1;
                end else begin
                    val = m_mem.exists(key) ? m_mem[key] : 'x;
                    if (m_armed && !inj_clr && b == m_bank && int'(addr[b]) == m_addr) begin
                        val = val ^ m_mask;
                        hit = 1;
                    end
                    m_out[b] = val;
                end
            end
        end
        if (hit && m_count < 255) m_count++;
        if (inj_clr) m_armed = 0;
        else if (inj_en) begin
            m_armed = 1; m_sticky = inj_sticky; m_bank = int'(inj_bank);
            m_addr = int'(inj_addr); m_mask = {inj_emask, inj_dmask};
        end else if ((hit && !m_sticky) || kill) m_armed = 0;
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s dout%0d", tag, b), 64'(dout[b]), 64'(m_out[b][DW-1:0]));
            chk($sformatf("%s ecc%0d", tag, b), 64'(ecc[b]), 64'(m_out[b][EW+DW-1:DW]));
        end
        chk({tag, " armed"}, 64'(inj_armed), 64'(m_armed));
        chk({tag, " count"}, 64'(inj_count), 64'(m_count));
        clear_inputs();
    endtask

    task automatic set_wr(input int b, input int a, input logic [DW-1:0] d, input logic [EW-1:0] e);
        clken[b] = 1; wren[b] = 1; addr[b] = AW'(a); wd[b] = d; we[b] = e;
    endtask

    task automatic set_rd(input int b, input int a);
        clken[b] = 1; wren[b] = 0; addr[b] = AW'(a);
    endtask

    task automatic set_arm(input int b, input int a, input logic [DW-1:0] dm,
                           input logic [EW-1:0] em, input bit st);
        inj_en = 1; inj_bank = 2'(b); inj_addr = AW'(a);
        inj_dmask = dm; inj_emask = em; inj_sticky = st;
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [EW-1:0] ve;
        int r;
        m_armed = 0; m_sticky = 0; m_bank = 0; m_addr = 0; m_count = 0; m_mask = '0;
        for (int b = 0; b < NB; b++) m_out[b] = '0;
        clear_inputs();

        // Reset state
        rst_l = 0;
        step("rst0");
        step("rst1");
        chk("rst dout0", 64'(dout[0]), 64'h0);
        chk("rst count", 64'(inj_count), 64'h0);
        rst_l = 1;

        // 1: basic write/read/hold
        set_wr(0, 5, 32'hDEADBEEF, 7'h2A); step("t1 wr");
        set_rd(0, 5);                      step("t1 rd");
        chk("t1 dout", 64'(dout[0]), 64'hDEADBEEF);
        chk("t1 ecc", 64'(ecc[0]), 64'h2A);
        step("t1 hold");
        chk("t1 hold dout", 64'(dout[0]), 64'hDEADBEEF);

        // 2: all banks together
        for (int b = 0; b < NB; b++) set_wr(b, 100 + b, $urandom, 7'($urandom));
        step("t2 wr");
        for (int b = 0; b < NB; b++) set_rd(b, 100 + b);
        step("t2 rd");

        // 3: one-shot injection
        set_wr(1, 16, 32'h12345678, 7'h11); step("t3 wr");
        set_arm(1, 16, 32'h1, 7'h0, 0);     step("t3 arm");
        set_rd(1, 16);                      step("t3 rd1");
        chk("t3 corrupt", 64'(dout[1]), 64'h12345679);
        set_rd(1, 16);                      step("t3 rd2");
        chk("t3 clean", 64'(dout[1]), 64'h12345678);
        chk("t3 count", 64'(inj_count), 64'd1);
        chk("t3 armed", 64'(inj_armed), 64'd0);

        // 4: sticky injection on ecc bit 6, then clear
        set_wr(2, 3, 32'hCAFEF00D, 7'h05); step("t4 wr");
        set_arm(2, 3, 32'h0, 7'h40, 1);    step("t4 arm");
        for (int i = 0; i < 3; i++) begin
            set_rd(2, 3); step("t4 rd");
            chk("t4 ecc", 64'(ecc[2]), 64'h45);
        end
        chk("t4 count", 64'(inj_count), 64'd4);
        inj_clr = 1;                       step("t4 clr");
        set_rd(2, 3);                      step("t4 rd clean");
        chk("t4 clean ecc", 64'(ecc[2]), 64'h05);

        // 5: write to target disarms a one-shot
        set_wr(3, 7, 32'h0BADF00D, 7'h33); step("t5 wr");
        set_arm(3, 7, 32'hFFFF, 7'h7F, 0); step("t5 arm");
        set_wr(3, 7, 32'h600DF00D, 7'h1C); step("t5 overwrite");
        set_rd(3, 7);                      step("t5 rd");
        chk("t5 dout", 64'(dout[3]), 64'h600DF00D);
        chk("t5 armed", 64'(inj_armed), 64'd0);
        chk("t5 count", 64'(inj_count), 64'd4);

        // 6: clr beats en; clr beats a same-cycle hit
        set_arm(0, 5, 32'hF, 7'h1, 0);     step("t6 arm");
        set_arm(0, 5, 32'hF, 7'h1, 0); inj_clr = 1; step("t6 clr+en");
        chk("t6 armed", 64'(inj_armed), 64'd0);
        set_arm(0, 5, 32'hF0, 7'h1, 1);    step("t6 arm2");
        set_rd(0, 5); inj_clr = 1;         step("t6 clr+hit");
        chk("t6 no corrupt", 64'(dout[0]), 64'hDEADBEEF);

        // Reset mid-operation
        set_rd(0, 5);                      step("rst rd");
        rst_l = 0;                         step("rst mid");
        chk("rst mid dout", 64'(dout[0]), 64'h0);
        chk("rst mid count", 64'(inj_count), 64'h0);
        rst_l = 1;

        // Random traffic over a small known-written row set
        for (int i = 0; i < 9; i++) begin
            for (int b = 0; b < NB; b++) set_wr(b, rows[i], $urandom, 7'($urandom));
            step("pre");
        end
        for (int n = 0; n < 200; n++) begin
            for (int b = 0; b < NB; b++) begin
                r = rows[$urandom_range(8, 0)];
                case ($urandom_range(2, 0))
                    0: ;
                    1: begin v = $urandom; ve = 7'($urandom); set_wr(b, r, v, ve); end
                    default: set_rd(b, r);
                endcase
            end
            if ($urandom_range(9, 0) == 0)
                set_arm($urandom_range(3, 0), rows[$urandom_range(8, 0)], $urandom,
                        7'($urandom), 1'($urandom));
            if ($urandom_range(19, 0) == 0) inj_clr = 1;
            step("rnd");
        end

        // Saturation
        set_arm(0, 5, 32'h80000000, 7'h0, 1); step("sat arm");
        for (int i = 0; i < 300; i++) begin
            set_rd(0, 5); step("sat");
        end
        chk("sat count", 64'(inj_count), 64'd255);
        chk("sat armed", 64'(inj_armed), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
